// File: rtl/nv_ram_rws_32x512_fifo_ctrl.sv
// Valid/ready FIFO controller driving an external 32x512 read/write-separate RAM plus a 2-entry output buffer.
// Optional registered fill-level output enabled by defining NV_RAM_RWS_FIFO_LVL_EN.
module nv_ram_rws_32x512_fifo_ctrl #(
    parameter int DW = 512,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_di,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd,
    output logic [31:0]   ram_pd
`ifdef NV_RAM_RWS_FIFO_LVL_EN
   ,output logic [AW:0]   fifo_lvl
`endif
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic [AW:0]   ram_cnt_nxt;
    logic          infl;
    logic [1:0]    out_cnt;
    logic [1:0]    out_cnt_nxt;
    logic [DW-1:0] buf0;
    logic [DW-1:0] buf1;
    logic [DW-1:0] buf0_nxt;
    logic [DW-1:0] buf1_nxt;
    logic          wr_acc;
    logic          rd_pop;
    logic          rd_iss;
    logic [2:0]    occ_after;

    // Both handshakes are gated by reset so nothing is accepted or issued in a reset cycle.
    assign wr_prdy   = ~reset & (ram_cnt != DEPTH);
    assign wr_acc    = wr_pvld & wr_prdy;
    assign rd_pvld   = (out_cnt != 2'd0);
    assign rd_pop    = rd_pvld & rd_prdy;
    assign occ_after = {1'b0, out_cnt} + {2'b00, infl} - {2'b00, rd_pop};
    assign rd_iss    = ~reset & (ram_cnt != '0) & (occ_after < 3'd2);

    assign ram_we = wr_acc;
    assign ram_wa = wr_ptr;
    assign ram_di = wr_pd;
    assign ram_re = rd_iss;
    assign ram_ra = rd_ptr;
    assign rd_pd  = buf0;
    assign ram_pd = pwrbus_ram_pd;

    assign ram_cnt_nxt = ram_cnt + (AW+1)'(wr_acc) - (AW+1)'(rd_iss);

    // RAM data is only valid in the cycle after the read, so a capture never waits.
    always_comb begin
        buf0_nxt    = buf0;
        buf1_nxt    = buf1;
        out_cnt_nxt = out_cnt;
        case ({infl, rd_pop})
            2'b10: begin
                if (out_cnt == 2'd0) begin
                    buf0_nxt = ram_dout;
                end else begin
                    buf1_nxt = ram_dout;
                end
                out_cnt_nxt = out_cnt + 2'd1;
            end
            2'b01: begin
                buf0_nxt    = buf1;
                out_cnt_nxt = out_cnt - 2'd1;
            end
            2'b11: begin
                if (out_cnt == 2'd1) begin
                    buf0_nxt = ram_dout;
                end else begin
                    buf0_nxt = buf1;
                    buf1_nxt = ram_dout;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            infl    <= 1'b0;
            out_cnt <= 2'd0;
            buf0    <= '0;
            buf1    <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_iss) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ram_cnt <= ram_cnt_nxt;
            infl    <= rd_iss;
            out_cnt <= out_cnt_nxt;
            buf0    <= buf0_nxt;
            buf1    <= buf1_nxt;
        end
    end

`ifdef NV_RAM_RWS_FIFO_LVL_EN
    logic [AW:0] lvl_nxt;

    assign lvl_nxt = ram_cnt_nxt + (AW+1)'(rd_iss) + (AW+1)'(out_cnt_nxt);

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_lvl <= '0;
        end else begin
            fifo_lvl <= lvl_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_nv_ram_rws_32x512_fifo_ctrl.sv
// Bench for nv_ram_rws_32x512_fifo_ctrl: queue-based reference model, behavioural RAM, directed and random traffic.
module tb_nv_ram_rws_32x512_fifo_ctrl;
    localparam int DW = 512;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_pvld;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd;
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_di;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_dout;
    logic [31:0]   pwrbus_ram_pd;
    logic [31:0]   ram_pd;
`ifdef NV_RAM_RWS_FIFO_LVL_EN
    logic [AW:0]   fifo_lvl;
`endif

    nv_ram_rws_32x512_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
        .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
        .ram_re(ram_re), .ram_ra(ram_ra), .ram_dout(ram_dout),
        .pwrbus_ram_pd(pwrbus_ram_pd), .ram_pd(ram_pd)
`ifdef NV_RAM_RWS_FIFO_LVL_EN
       ,.fifo_lvl(fifo_lvl)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // RAM: read-before-write, data valid only in the cycle after the read, garbage otherwise.
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        ram_dout <= ram_re ? mem[ram_ra] : rnd_word();
    end

    logic [DW-1:0] ram_q [$];
    logic [DW-1:0] out_q [$];
    logic [DW-1:0] fl_w;
    logic          fl_v = 1'b0;
    logic [AW-1:0] mwa = '0;
    logic [AW-1:0] mra = '0;
    logic          e_prdy, e_pvld, e_re, m_pop, m_acc;
    int            occ;

    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            chk("wr_prdy_in_reset", {511'd0, wr_prdy}, '0);
            ram_q.delete();
            out_q.delete();
            fl_v = 1'b0;
            mwa = '0;
            mra = '0;
        end else begin
            e_prdy = (ram_q.size() != 32);
            e_pvld = (out_q.size() != 0);
            m_pop  = e_pvld & rd_prdy;
            m_acc  = wr_pvld & e_prdy;
            occ    = out_q.size() + int'(fl_v) - int'(m_pop);
            e_re   = (ram_q.size() != 0) && (occ < 2);
            chk("wr_prdy", {511'd0, wr_prdy}, {511'd0, e_prdy});
            chk("rd_pvld", {511'd0, rd_pvld}, {511'd0, e_pvld});
            if (e_pvld) chk("rd_pd", rd_pd, out_q[0]);
            chk("ram_we", {511'd0, ram_we}, {511'd0, m_acc});
            if (m_acc) begin
                chk("ram_wa", {507'd0, ram_wa}, {507'd0, mwa});
                chk("ram_di", ram_di, wr_pd);
            end
            chk("ram_re", {511'd0, ram_re}, {511'd0, e_re});
            if (e_re) chk("ram_ra", {507'd0, ram_ra}, {507'd0, mra});
            chk("ram_pd", {480'd0, ram_pd}, {480'd0, pwrbus_ram_pd});
`ifdef NV_RAM_RWS_FIFO_LVL_EN
            chk("fifo_lvl", {506'd0, fifo_lvl}, DW'(ram_q.size() + int'(fl_v) + out_q.size()));
`endif
            if (m_pop) void'(out_q.pop_front());
            if (fl_v) out_q.push_back(fl_w);
            fl_v = e_re;
            if (e_re) begin
                fl_w = ram_q.pop_front();
                mra++;
            end
            if (m_acc) begin
                ram_q.push_back(wr_pd);
                mwa++;
            end
        end
    end

    logic          rst_req = 1'b1;
    logic          s_prdy, s_pvld, s_we, s_re, s_acc;
    logic [AW-1:0] s_wa, s_ra;
    logic [DW-1:0] s_pd;
    logic [AW:0]   s_lvl;

    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        @(negedge clk);
        reset = rst_req;
        wr_pvld = v;
        wr_pd = d;
        rd_prdy = r;
        pwrbus_ram_pd = $urandom;
        #3;
        s_prdy = wr_prdy;
        s_acc  = v & wr_prdy;
        s_pvld = rd_pvld;
        s_pd   = rd_pd;
        s_we   = ram_we;
        s_wa   = ram_wa;
        s_re   = ram_re;
        s_ra   = ram_ra;
`ifdef NV_RAM_RWS_FIFO_LVL_EN
        s_lvl  = fifo_lvl;
`else
        s_lvl  = '0;
`endif
    endtask

    logic [DW-1:0] a5, xw, first_pd;
    int acc, res, pops, first, last;
    logic [AW-1:0] r_ra;
    logic got;

    initial begin
        reset = 1'b1; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0; pwrbus_ram_pd = '0;
        a5 = {64{8'hA5}};
        repeat (3) step(1'b0, '0, 1'b0);
        rst_req = 1'b0;
        step(1'b0, '0, 1'b1);
        chk("rst_wr_prdy", {511'd0, s_prdy}, 1);
        chk("rst_rd_pvld", {511'd0, s_pvld}, 0);
        chk("rst_rd_pd", s_pd, 0);
        chk("rst_ram_re", {511'd0, s_re}, 0);

        // single write latency
        step(1'b1, a5, 1'b1);
        chk("lat_we_T", {511'd0, s_we}, 1);
        chk("lat_wa_T", {507'd0, s_wa}, 0);
        step(1'b0, '0, 1'b1);
        chk("lat_re_T1", {511'd0, s_re}, 1);
        chk("lat_ra_T1", {507'd0, s_ra}, 0);
        step(1'b0, '0, 1'b1);
        chk("lat_pvld_T2", {511'd0, s_pvld}, 0);
        step(1'b0, '0, 1'b1);
        chk("lat_pvld_T3", {511'd0, s_pvld}, 1);
        chk("lat_pd_T3", s_pd, a5);
        repeat (4) step(1'b0, '0, 1'b1);

        // fill with consumer stalled, then drain
        acc = 0; res = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, rnd_word(), 1'b0);
            acc += int'(s_acc);
            res += int'(s_re);
        end
        chk("fill_accepted", DW'(acc), 34);
        chk("fill_reads", DW'(res), 2);
        chk("fill_wr_prdy", {511'd0, s_prdy}, 0);
        pops = 0; first = -1; last = -1;
        for (int i = 0; i < 45; i++) begin
            step(1'b0, '0, 1'b1);
            if (s_pvld) begin
                pops++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("drain_pops", DW'(pops), 34);
        chk("drain_no_gaps", DW'(last - first), 33);

        // freed slot rewritten the cycle after its read issue
        for (int i = 0; i < 40; i++) step(1'b1, rnd_word(), 1'b0);
        step(1'b1, rnd_word(), 1'b1);
        chk("rewrite_issue", {511'd0, s_re}, 1);
        chk("rewrite_blocked", {511'd0, s_acc}, 0);
        r_ra = s_ra;
        step(1'b1, rnd_word(), 1'b1);
        chk("rewrite_acc", {511'd0, s_acc}, 1);
        chk("rewrite_addr", {507'd0, s_wa}, {507'd0, r_ra});
        repeat (45) step(1'b0, '0, 1'b1);

        // continuous streaming with pointer wrap
        acc = 0; pops = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, rnd_word(), 1'b1);
            acc += int'(s_acc);
            pops += int'(s_pvld);
        end
        chk("stream_accepted", DW'(acc), 1000);
        chk("stream_rate", {511'd0, (pops >= 997)}, 1);
        repeat (10) step(1'b0, '0, 1'b1);

        // reset with words buffered
        for (int i = 0; i < 10; i++) step(1'b1, rnd_word(), 1'b0);
        rst_req = 1'b1;
        step(1'b0, '0, 1'b0);
        rst_req = 1'b0;
        step(1'b0, '0, 1'b0);
        chk("post_rst_pvld", {511'd0, s_pvld}, 0);
        chk("post_rst_prdy", {511'd0, s_prdy}, 1);
`ifdef NV_RAM_RWS_FIFO_LVL_EN
        chk("post_rst_lvl", {506'd0, s_lvl}, 0);
`endif
        xw = rnd_word();
        step(1'b1, xw, 1'b1);
        got = 1'b0; first_pd = '0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1);
            if (s_pvld && !got) begin
                got = 1'b1;
                first_pd = s_pd;
            end
        end
        chk("post_rst_seen", {511'd0, got}, 1);
        chk("post_rst_first", first_pd, xw);

        // random traffic
        for (int i = 0; i < 10000; i++)
            step($urandom_range(0, 99) < 70, rnd_word(), 1'($urandom_range(0, 1)));
        repeat (50) step(1'b0, '0, 1'b1);
        chk("final_empty", {511'd0, s_pvld}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
